// File: rtl/t06_lcd_page_arbiter.sv
// Arbitrates the 2x16 LCD text between an alert requester, a normal requester
// and the live default page; granted messages are held for HOLD_CYCLES cycles.
`timescale 1ns/1ps
module t06_lcd_page_arbiter #(
    parameter int unsigned HOLD_CYCLES = 1000000,
    parameter int unsigned CNT_W       = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic [127:0] req0_row1,
    input  logic [127:0] req0_row2,
    output logic         ack0,
    input  logic         req1,
    input  logic [127:0] req1_row1,
    input  logic [127:0] req1_row2,
    output logic         ack1,
    input  logic [127:0] def_row1,
    input  logic [127:0] def_row2,
    input  logic         clear,
    output logic [127:0] row_1,
    output logic [127:0] row_2,
    output logic [1:0]   src,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW0 = 2'd1,
        SHOW1 = 2'd2
    } state_t;

    localparam logic [127:0]     BLANK     = {16{8'h20}};
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [127:0]       row_1_q, row_1_d;
    logic [127:0]       row_2_q, row_2_d;
    logic               ack0_q, ack0_d;
    logic               ack1_q, ack1_d;
    logic [1:0]         src_q, src_d;
    logic               busy_q, busy_d;

    logic elig0, elig1;
    logic do_g0, do_g1, do_idle, do_dec;

    // A requester still holding req during its own ack cycle must not be re-granted.
    assign elig0 = req0 & ~ack0_q;
    assign elig1 = req1 & ~ack1_q;

    always_comb begin
        do_g0   = 1'b0;
        do_g1   = 1'b0;
        do_idle = 1'b0;
        do_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (elig0)      do_g0   = 1'b1;
                else if (elig1) do_g1   = 1'b1;
                else            do_idle = 1'b1;
            end
            SHOW1: begin
                if (clear)                 do_idle = 1'b1;
                else if (elig0)            do_g0   = 1'b1;
                else if (hold_cnt_q == '0) begin
                    if (elig1) do_g1   = 1'b1;
                    else       do_idle = 1'b1;
                end
                else                       do_dec  = 1'b1;
            end
            SHOW0: begin
                if (clear)                 do_idle = 1'b1;
                else if (hold_cnt_q == '0) begin
                    if (elig0)      do_g0   = 1'b1;
                    else if (elig1) do_g1   = 1'b1;
                    else            do_idle = 1'b1;
                end
                else                       do_dec  = 1'b1;
            end
            default: do_idle = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        row_1_d    = row_1_q;
        row_2_d    = row_2_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        src_d      = src_q;
        if (do_g0) begin
            state_d    = SHOW0;
            hold_cnt_d = HOLD_LOAD;
            row_1_d    = req0_row1;
            row_2_d    = req0_row2;
            ack0_d     = 1'b1;
            src_d      = 2'b01;
        end
        else if (do_g1) begin
            state_d    = SHOW1;
            hold_cnt_d = HOLD_LOAD;
            row_1_d    = req1_row1;
            row_2_d    = req1_row2;
            ack1_d     = 1'b1;
            src_d      = 2'b10;
        end
        else if (do_idle) begin
            // Leaving edge loads the default page so there is no blank frame.
            state_d    = IDLE;
            hold_cnt_d = '0;
            row_1_d    = def_row1;
            row_2_d    = def_row2;
            src_d      = 2'b00;
        end
        else if (do_dec) begin
            hold_cnt_d = hold_cnt_q - CNT_W'(1);
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            row_1_q    <= BLANK;
            row_2_q    <= BLANK;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            src_q      <= 2'b00;
            busy_q     <= 1'b0;
        end
        else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            row_1_q    <= row_1_d;
            row_2_q    <= row_2_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            src_q      <= src_d;
            busy_q     <= busy_d;
        end
    end

    assign row_1 = row_1_q;
    assign row_2 = row_2_q;
    assign ack0  = ack0_q;
    assign ack1  = ack1_q;
    assign src   = src_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_t06_lcd_page_arbiter.sv
// Directed scoreboard bench for t06_lcd_page_arbiter with HOLD_CYCLES=4.
`timescale 1ns/1ps
module tb_t06_lcd_page_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1, clear;
    logic [127:0] req0_row1, req0_row2, req1_row1, req1_row2;
    logic [127:0] def_row1, def_row2;
    logic         ack0, ack1, busy;
    logic [127:0] row_1, row_2;
    logic [1:0]   src;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string        tag;
        logic [260:0] v;
    } exp_t;
    exp_t sb[$];

    t06_lcd_page_arbiter #(.HOLD_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req0_row1(req0_row1), .req0_row2(req0_row2), .ack0(ack0),
        .req1(req1), .req1_row1(req1_row1), .req1_row2(req1_row2), .ack1(ack1),
        .def_row1(def_row1), .def_row2(def_row2), .clear(clear),
        .row_1(row_1), .row_2(row_2), .src(src), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] txt(input string s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            r[127 - 8*i -: 8] = (i < s.len()) ? s[i] : 8'h20;
        end
        return r;
    endfunction

    task automatic check_front();
        exp_t         e;
        logic [260:0] got;
        e   = sb.pop_front();
        got = {row_1, row_2, src, busy, ack0, ack1};
        tests++;
        assert (got === e.v) else begin
            fails++;
            $error("FAIL %s: got row1=%h row2=%h src=%b busy=%b ack0=%b ack1=%b, expected row1=%h row2=%h src=%b busy=%b ack0=%b ack1=%b",
                   e.tag, got[260:133], got[132:5], got[4:3], got[2], got[1], got[0],
                   e.v[260:133], e.v[132:5], e.v[4:3], e.v[2], e.v[1], e.v[0]);
        end
    endtask

    // Push the expectation, optionally advance one clock, then compare.
    task automatic step(input string tag, input bit adv,
                        input logic [127:0] r1, input logic [127:0] r2,
                        input logic [1:0] s, input logic b,
                        input logic a0, input logic a1);
        exp_t e;
        e.tag = tag;
        e.v   = {r1, r2, s, b, a0, a1};
        sb.push_back(e);
        if (adv) begin
            @(posedge clk);
            #1;
        end
        check_front();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

    initial begin
        logic [127:0] sp, d1, d2, a1, a2, n1, n2;
        sp = {16{8'h20}};
        d1 = txt("SCORE 0000");
        d2 = txt("LVL 1");
        a1 = txt("ALERT: LOW HP");
        a2 = txt("PRESS START");
        n1 = txt("LEVEL UP!");
        n2 = txt("BONUS +500");

        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; clear = 1'b0;
        def_row1 = d1; def_row2 = d2;
        req0_row1 = a1; req0_row2 = a2;
        req1_row1 = n1; req1_row2 = n2;

        // 1: reset state and default page
        step("rst_blank", 1, sp, sp, 2'b00, 1'b0, 1'b0, 1'b0);
        step("rst_blank2", 1, sp, sp, 2'b00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step("def_after_release", 1, d1, d2, 2'b00, 1'b0, 1'b0, 1'b0);
        def_row1 = txt("SCORE 0010");
        step("def_lag_old", 0, d1, d2, 2'b00, 1'b0, 1'b0, 1'b0);
        d1 = def_row1;
        step("def_lag_new", 1, d1, d2, 2'b00, 1'b0, 1'b0, 1'b0);

        // 2: req1 with registered requester, frozen text, exact hold
        req1 = 1'b1;
        step("t2_grant", 1, n1, n2, 2'b10, 1'b1, 1'b0, 1'b1);
        req1_row1 = txt("GARBAGE");
        step("t2_no_regrant", 1, n1, n2, 2'b10, 1'b1, 1'b0, 1'b0);
        req1 = 1'b0;
        step("t2_hold3", 1, n1, n2, 2'b10, 1'b1, 1'b0, 1'b0);
        step("t2_hold4", 1, n1, n2, 2'b10, 1'b1, 1'b0, 1'b0);
        step("t2_expire", 1, d1, d2, 2'b00, 1'b0, 1'b0, 1'b0);
        req1_row1 = n1;

        // 3: req0 preempts a req1 message two cycles in
        req1 = 1'b1;
        step("t3_grant1", 1, n1, n2, 2'b10, 1'b1, 1'b0, 1'b1);
        step("t3_show1", 1, n1, n2, 2'b10, 1'b1, 1'b0, 1'b0);
        req1 = 1'b0; req0 = 1'b1;
        step("t3_preempt", 1, a1, a2, 2'b01, 1'b1, 1'b1, 1'b0);
        step("t3_hold2", 1, a1, a2, 2'b01, 1'b1, 1'b0, 1'b0);
        req0 = 1'b0;
        step("t3_hold3", 1, a1, a2, 2'b01, 1'b1, 1'b0, 1'b0);
        step("t3_hold4", 1, a1, a2, 2'b01, 1'b1, 1'b0, 1'b0);
        step("t3_expire", 1, d1, d2, 2'b00, 1'b0, 1'b0, 1'b0);
        step("t3_no_resume", 1, d1, d2, 2'b00, 1'b0, 1'b0, 1'b0);

        // 4: req1 waits through a req0 message, then contiguous window
        req0 = 1'b1;
        step("t4_grant0", 1, a1, a2, 2'b01, 1'b1, 1'b1, 1'b0);
        step("t4_hold2", 1, a1, a2, 2'b01, 1'b1, 1'b0, 1'b0);
        req0 = 1'b0; req1 = 1'b1;
        step("t4_wait3", 1, a1, a2, 2'b01, 1'b1, 1'b0, 1'b0);
        step("t4_wait4", 1, a1, a2, 2'b01, 1'b1, 1'b0, 1'b0);
        step("t4_grant1", 1, n1, n2, 2'b10, 1'b1, 1'b0, 1'b1);
        step("t4_n_hold2", 1, n1, n2, 2'b10, 1'b1, 1'b0, 1'b0);
        req1 = 1'b0;
        step("t4_n_hold3", 1, n1, n2, 2'b10, 1'b1, 1'b0, 1'b0);
        step("t4_n_hold4", 1, n1, n2, 2'b10, 1'b1, 1'b0, 1'b0);
        step("t4_expire", 1, d1, d2, 2'b00, 1'b0, 1'b0, 1'b0);

        // 5: clear wins over req0 in SHOW1, req0 granted next edge
        req1 = 1'b1;
        step("t5_grant1", 1, n1, n2, 2'b10, 1'b1, 1'b0, 1'b1);
        step("t5_show1", 1, n1, n2, 2'b10, 1'b1, 1'b0, 1'b0);
        req1 = 1'b0; clear = 1'b1; req0 = 1'b1;
        step("t5_clear", 1, d1, d2, 2'b00, 1'b0, 1'b0, 1'b0);
        clear = 1'b0;
        step("t5_grant0", 1, a1, a2, 2'b01, 1'b1, 1'b1, 1'b0);
        step("t5_hold2", 1, a1, a2, 2'b01, 1'b1, 1'b0, 1'b0);
        req0 = 1'b0; req1 = 1'b1;
        step("t5_hold3", 1, a1, a2, 2'b01, 1'b1, 1'b0, 1'b0);

        // 6: async reset between edges mid-SHOW0 with req1 pending
        #2;
        rst = 1'b1;
        #1;
        step("t6_async", 0, sp, sp, 2'b00, 1'b0, 1'b0, 1'b0);
        step("t6_held", 1, sp, sp, 2'b00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0; req1 = 1'b0;
        step("t6_release", 1, d1, d2, 2'b00, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
